// File: rtl/yolo_pkg.sv
// Shared definitions for the YOLO streaming datapath: the FP16 word type and
// the two-state handshake FSM encoding reused by the streaming stages.
package yolo_pkg;

   localparam int DATA_WIDTH = 16;

   typedef logic [15:0] fp16_t;

   // FILL: accepting stream words; HOLD: presenting a complete frame downstream.
   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } ld_state_t;

endpackage : yolo_pkg

// File: rtl/fmap_slot_reg.sv
// One word slot of the feature-map buffer: a write-enabled register with a
// synchronous active-high reset.
module fmap_slot_reg #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   // Capture the incoming word when this slot is addressed.
   always_ff @(posedge clk) begin
      // NOTE: the buffer is reset because the frame output must read zero after
      // reset; a buffer with no such visible reset value could skip it.
      if (reset) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule : fmap_slot_reg

// File: rtl/fmap_loader.sv
// fmap_loader: collects a serial FP16 stream into one flat D*H*W frame for
// CSP1_3 and holds it until the consumer acknowledges it.
// Build option: define FMAP_LOADER_LAST_CHECK_EN to flag in_last framing
// errors on err; otherwise in_last is ignored and err stays low.
module fmap_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int D          = 3,
   parameter int H          = 4,
   parameter int W          = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_last,
   output logic [D*H*W*DATA_WIDTH-1:0]       fmap_out,
   output logic                              fmap_valid,
   input  logic                              fmap_ack,
   output logic [$clog2(D*H*W+1)-1:0]        fill_cnt,
   output logic                              err
);

   import yolo_pkg::*;

   localparam int N  = D * H * W;
   localparam int CW = $clog2(N + 1);

   ld_state_t     state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          valid_q, valid_n;
   logic          err_q, err_n;
   logic          xfer;
   logic          last_slot;

   // Words are only taken while filling, so ready is a pure decode of state.
   assign in_ready  = (state_q == FILL);
   assign xfer      = in_valid && in_ready;
   assign last_slot = (cnt_q == CW'(N - 1));

   // Buffer: slot k is written by the k-th transfer of the frame; slots are
   // never cleared on ack, only overwritten by the next frame.
   for (genvar k = 0; k < N; k++) begin : g_slot
      fmap_slot_reg #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_slot (
         .clk  (clk),
         .reset(reset),
         .we   (xfer && (cnt_q == CW'(k))),
         .d    (in_data),
         .q    (fmap_out[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Next-state, counter and frame-valid decode.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave one unassigned and infer a latch.
      state_n = state_q;
      cnt_n   = cnt_q;
      valid_n = valid_q;
      unique case (state_q)
         FILL: begin
            if (xfer) begin
               cnt_n = cnt_q + 1'b1;
               if (last_slot) begin
                  state_n = HOLD;
                  valid_n = 1'b1;
               end
            end
         end
         HOLD: begin
            if (fmap_ack) begin
               state_n = FILL;
               valid_n = 1'b0;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = FILL;
            valid_n = 1'b0;
            cnt_n   = '0;
         end
      endcase
   end

`ifdef FMAP_LOADER_LAST_CHECK_EN
   // Framing check: in_last must mark exactly the word that fills slot N-1.
   // Completion still follows the count; in_last never resynchronises.
   always_comb begin
      err_n = xfer && (in_last != last_slot);
   end
`else
   // Framing check disabled: in_last is ignored and err never fires.
   logic unused_in_last;
   assign unused_in_last = in_last;
   always_comb begin
      err_n = 1'b0;
   end
`endif

   // State, counter and flag registers; reset wins over transfer and ack.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= FILL;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         valid_q <= valid_n;
         err_q   <= err_n;
      end
   end

   assign fmap_valid = valid_q;
   assign fill_cnt   = cnt_q;
   assign err        = err_q;

endmodule : fmap_loader

// File: tb/tb_fmap_loader.sv
// Self-checking bench for fmap_loader: directed scenarios with random data,
// compared every cycle against a frame-level reference model.
module tb_fmap_loader;

   localparam int DW = 16;
   localparam int D  = 3;
   localparam int H  = 4;
   localparam int W  = 4;
   localparam int N  = D * H * W;
   localparam int CW = $clog2(N + 1);
`ifdef FMAP_LOADER_LAST_CHECK_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [DW-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [N*DW-1:0]   fmap_out;
   logic              fmap_valid;
   logic              fmap_ack;
   logic [CW-1:0]     fill_cnt;
   logic              err;

   int checks   = 0;
   int failures = 0;

   // Reference model: words accepted in the current frame, the frame image,
   // whether a complete frame is being held, and the expected error pulse.
   logic [DW-1:0]     got[$];
   logic [N*DW-1:0]   exp_frame;
   bit                holding;
   bit                exp_err;
   int                err_seen;
   int                err_want;

   fmap_loader #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .fmap_out  (fmap_out),
      .fmap_valid(fmap_valid),
      .fmap_ack  (fmap_ack),
      .fill_cnt  (fill_cnt),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model by the spec's rules, compare.
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic a, input logic r);
      in_valid = v; in_data = d; in_last = l; fmap_ack = a; reset = r;
      @(posedge clk);
      #1;
      exp_err = 1'b0;
      if (r) begin
         got.delete();
         exp_frame = '0;
         holding   = 1'b0;
      end else if (!holding) begin
         if (v) begin
            exp_err = LAST_EN && (l != (got.size() == N - 1));
            exp_frame[got.size()*DW +: DW] = d;
            got.push_back(d);
            if (got.size() == N) holding = 1'b1;
         end
      end else if (a) begin
         holding = 1'b0;
         got.delete();
      end
      if (err === 1'b1) err_seen++;
      if (exp_err) err_want++;
      check("in_ready",   32'(in_ready),   32'(!holding));
      check("fmap_valid", 32'(fmap_valid), 32'(holding));
      check("fill_cnt",   32'(fill_cnt),   32'(got.size()));
      check("err",        32'(err),        32'(exp_err));
      check_frame("fmap_out", fmap_out, exp_frame);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [N*DW-1:0] held;
      logic [DW-1:0]   rd;
      exp_frame = '0;
      holding   = 1'b0;
      err_seen  = 0;
      err_want  = 0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; fmap_ack = 1'b0; reset = 1'b1;

      // Reset state.
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      check("reset_fill_cnt", 32'(fill_cnt), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // 1: back-to-back words 1..48, in_last on the final word.
      for (int k = 1; k <= N; k++) cycle(1'b1, DW'(k), (k == N), 1'b0, 1'b0);
      check("t1_valid",  32'(fmap_valid), 32'd1);
      check("t1_first",  32'(fmap_out[0 +: DW]), 32'h0001);
      check("t1_last",   32'(fmap_out[47*DW +: DW]), 32'h0030);
      check("t1_cnt",    32'(fill_cnt), 32'd48);

      // 2: hold for 10 cycles with junk offered, then ack.
      held = fmap_out;
      for (int i = 0; i < 10; i++) cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      check_frame("t2_hold_stable", fmap_out, held);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      check("t2_ack_valid", 32'(fmap_valid), 32'd0);
      check("t2_ack_cnt",   32'(fill_cnt), 32'd0);
      check("t2_ack_ready", 32'(in_ready), 32'd1);

      // 3: in_valid toggling with random data; completes after 96 cycles.
      for (int i = 0; i < 2*N; i++) begin
         rd = DW'($urandom);
         cycle(i[0] == 1'b0, rd, (i == 2*N - 2), 1'b0, 1'b0);
      end
      check("t3_valid", 32'(fmap_valid), 32'd1);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

      // 4: reset after 20 words, then a clean random frame.
      for (int k = 0; k < 20; k++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b1);
      check("t4_rst_cnt",   32'(fill_cnt), 32'd0);
      check("t4_rst_valid", 32'(fmap_valid), 32'd0);
      check_frame("t4_rst_frame", fmap_out, '0);
      for (int k = 0; k < N; k++) cycle(1'b1, DW'($urandom), (k == N - 1), 1'b0, 1'b0);
      check("t4_valid", 32'(fmap_valid), 32'd1);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

      // 5: early in_last on word 30, no in_last on word 48.
      err_seen = 0;
      err_want = 0;
      for (int k = 1; k <= N; k++) cycle(1'b1, DW'($urandom), (k == 30), 1'b0, 1'b0);
      check("t5_valid", 32'(fmap_valid), 32'd1);
      idle(2);
      check("t5_err_pulses", 32'(err_seen), LAST_EN ? 32'd2 : 32'd0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

      // 6: ack during FILL at word 10 is ignored.
      for (int k = 1; k <= N; k++) cycle(1'b1, DW'($urandom), (k == N), (k == 10), 1'b0);
      check("t6_valid", 32'(fmap_valid), 32'd1);
      check("t6_cnt",   32'(fill_cnt), 32'd48);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fmap_loader
